// File: rtl/uart_rgb_cmd_pkg.sv
// Shared constants, FSM encoding and ASCII helpers for the UART RGB command front-end.
package uart_rgb_cmd_pkg;

    localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;
    localparam int          NUM_CH     = 3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_G  = 8'h47;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] LC_BIT   = 8'h20;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;
    localparam logic [1:0] CH_NONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_SEND = 2'd3
    } cmd_state_e;

    typedef logic [NUM_CH-1:0][7:0] duty_vec_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Only meaningful when is_hex(c); letters of either case map via the low nibble.
    function automatic logic [3:0] hex_nib(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic logic [1:0] chan_of(input logic [7:0] c);
        logic [1:0] ch;
        ch = CH_NONE;
        if (c == ASCII_R || c == (ASCII_R | LC_BIT)) ch = CH_RED;
        if (c == ASCII_G || c == (ASCII_G | LC_BIT)) ch = CH_GREEN;
        if (c == ASCII_B || c == (ASCII_B | LC_BIT)) ch = CH_BLUE;
        return ch;
    endfunction

    function automatic logic is_off(input logic [7:0] c);
        return (c == ASCII_O) || (c == (ASCII_O | LC_BIT));
    endfunction

endpackage

// File: rtl/uart_rgb_cmd_pwm3.sv
// Three-channel 8-bit PWM: shared prescaler and phase counter, per-channel live
// duty registers that reload from the shadow values only at period start.
module rgb_pwm3
    import uart_rgb_cmd_pkg::*;
#(
    parameter int PWM_PRESCALE = 47
) (
    input  logic              hw_clk,
    input  logic              rst,
    input  duty_vec_t         duty_shadow,
    output logic [NUM_CH-1:0] pwm
);
    localparam int PW = (PWM_PRESCALE > 0) ? $clog2(PWM_PRESCALE + 1) : 1;

    logic [PW-1:0] presc_q;
    logic [7:0]    pc_q;
    duty_vec_t     live_q;
    logic          tick;

    assign tick = (presc_q == PW'(PWM_PRESCALE));

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            presc_q <= '0;
            pc_q    <= '0;
            live_q  <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                pc_q <= pc_q + 8'd1;
                // Reload on the wrap to 0 so a period never mixes two duties.
                if (pc_q == 8'hFF) live_q <= duty_shadow;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
        assign pwm[i] = (pc_q < live_q[i]);
    end

endmodule

// File: rtl/uart_rgb_cmd.sv
// UART command front-end: parses "<ch><hi><lo>" and "O" into per-colour duty
// shadow registers, answers each command with one ack byte, drives RGB PWM.
module uart_rgb_cmd
    import uart_rgb_cmd_pkg::*;
#(
    parameter int         PWM_PRESCALE = 47,
    parameter logic [7:0] ACK_OK       = 8'h4B,
    parameter logic [7:0] ACK_ERR      = 8'h3F
) (
    input  logic        hw_clk,
    input  logic        rst,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic        reg_dat_re,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    output logic        rgb_red,
    output logic        rgb_green,
    output logic        rgb_blue
);
    cmd_state_e        state_q, state_d;
    logic [7:0]        rx_byte, ack_q, ack_d;
    logic [1:0]        ch_q;
    logic [3:0]        hi_q;
    duty_vec_t         shadow_q;
    logic              cap, rx_hex, wr_duty, clr_duty;
    logic [NUM_CH-1:0] pwm;

    assign rx_byte = reg_dat_do[7:0];
    assign rx_hex  = is_hex(rx_byte);
    // The pop pulse blocks capture so a byte is never taken twice.
    assign cap     = (state_q != ST_SEND) && !reg_dat_re && (reg_dat_do != UART_EMPTY);

    always_ff @(posedge hw_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        wr_duty  = 1'b0;
        clr_duty = 1'b0;
        case (state_q)
            ST_IDLE: if (cap) begin
                if (chan_of(rx_byte) != CH_NONE) begin
                    state_d = ST_HI;
                end else if (is_off(rx_byte)) begin
                    clr_duty = 1'b1;
                    ack_d    = ACK_OK;
                    state_d  = ST_SEND;
                end else if (rx_byte != ASCII_CR && rx_byte != ASCII_LF) begin
                    ack_d   = ACK_ERR;
                    state_d = ST_SEND;
                end
            end
            ST_HI: if (cap) begin
                if (rx_hex) begin
                    state_d = ST_LO;
                end else begin
                    ack_d   = ACK_ERR;
                    state_d = ST_SEND;
                end
            end
            ST_LO: if (cap) begin
                wr_duty = rx_hex;
                ack_d   = rx_hex ? ACK_OK : ACK_ERR;
                state_d = ST_SEND;
            end
            ST_SEND: if (!reg_dat_wait) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_dat_we = (state_q == ST_SEND);
        reg_dat_di = reg_dat_we ? {24'h0, ack_q} : 32'h0;
    end

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            reg_dat_re <= 1'b0;
            ack_q      <= '0;
            ch_q       <= '0;
            hi_q       <= '0;
            shadow_q   <= '0;
        end else begin
            reg_dat_re <= cap;
            ack_q      <= ack_d;
            if (cap && state_q == ST_IDLE) ch_q <= chan_of(rx_byte);
            if (cap && state_q == ST_HI)   hi_q <= hex_nib(rx_byte);
            if (clr_duty)     shadow_q       <= '0;
            else if (wr_duty) shadow_q[ch_q] <= {hi_q, hex_nib(rx_byte)};
        end
    end

    rgb_pwm3 #(.PWM_PRESCALE(PWM_PRESCALE)) u_pwm (
        .hw_clk      (hw_clk),
        .rst         (rst),
        .duty_shadow (shadow_q),
        .pwm         (pwm)
    );

    assign rgb_red   = pwm[CH_RED];
    assign rgb_green = pwm[CH_GREEN];
    assign rgb_blue  = pwm[CH_BLUE];

endmodule

// File: tb/tb_uart_rgb_cmd.sv
// Bench for uart_rgb_cmd: queue-based UART model, command-level reference model,
// PWM duty measured as high-cycle count over one full period.
module tb_uart_rgb_cmd;
    localparam int P   = 1;
    localparam int PER = 256 * (P + 1);

    logic        hw_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg_dat_do = 32'hFFFF_FFFF;
    logic        reg_dat_wait = 1'b0;
    logic        reg_dat_re, reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        rgb_red, rgb_green, rgb_blue;

    int checks = 0, failures = 0, mon_err = 0, re_cnt = 0;
    int hi_cnt[3] = '{0, 0, 0};
    int mduty[3]  = '{0, 0, 0};
    logic        we_s = 1'b0, re_s = 1'b0;
    logic [31:0] di_s = '0;
    byte unsigned rxq[$], txq[$], exp_ack[$], pend[$];

    uart_rgb_cmd #(.PWM_PRESCALE(P), .ACK_OK(8'h4B), .ACK_ERR(8'h3F)) dut (
        .hw_clk       (hw_clk),
        .rst          (rst),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_di   (reg_dat_di),
        .rgb_red      (rgb_red),
        .rgb_green    (rgb_green),
        .rgb_blue     (rgb_blue)
    );

    always #5 hw_clk = ~hw_clk;

    // ---------------- reference model: command grammar on a byte stream
    function automatic bit m_hex(byte unsigned c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int m_val(byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    function automatic int m_ch(byte unsigned c);
        if (c == "R" || c == "r") return 0;
        if (c == "G" || c == "g") return 1;
        if (c == "B" || c == "b") return 2;
        return -1;
    endfunction

    task automatic model_byte(byte unsigned c);
        if (pend.size() == 0) begin
            if (c == 8'h0D || c == 8'h0A) return;
            if (c == "O" || c == "o") begin
                mduty = '{0, 0, 0};
                exp_ack.push_back(8'h4B);
            end else if (m_ch(c) >= 0) pend.push_back(c);
            else exp_ack.push_back(8'h3F);
        end else if (pend.size() == 1) begin
            if (m_hex(c)) pend.push_back(c);
            else begin pend.delete(); exp_ack.push_back(8'h3F); end
        end else begin
            if (m_hex(c)) begin
                mduty[m_ch(pend[0])] = m_val(pend[1]) * 16 + m_val(c);
                exp_ack.push_back(8'h4B);
            end else exp_ack.push_back(8'h3F);
            pend.delete();
        end
    endtask

    task automatic model_reset();
        mduty = '{0, 0, 0};
        pend.delete();
        exp_ack.delete();
    endtask

    // ---------------- UART side and per-cycle sampling (at negedge)
    task automatic refresh_do();
        reg_dat_do = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'hFFFF_FFFF;
    endtask

    task automatic tick();
        // wait/rst hold their value through the coming posedge, so acceptance is known now
        if (we_s && !reg_dat_wait && !rst) txq.push_back(di_s[7:0]);
        @(negedge hw_clk);
        we_s = reg_dat_we;
        di_s = reg_dat_di;
        if (di_s[31:8] != 24'h0) mon_err++;
        if (reg_dat_re) begin
            if (re_s) mon_err++;
            re_cnt++;
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
        re_s = reg_dat_re;
        if (rgb_red)   hi_cnt[0]++;
        if (rgb_green) hi_cnt[1]++;
        if (rgb_blue)  hi_cnt[2]++;
        refresh_do();
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) begin
            byte unsigned c;
            c = s[i];
            rxq.push_back(c);
            model_byte(c);
        end
        refresh_do();
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (!(rxq.size() == 0 && !we_s && !re_s) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s_idle: timed out with %0d bytes queued, we=%0d", name, rxq.size(), we_s);
        end
        repeat (3) tick();
    endtask

    task automatic check_acks(string name);
        checks++;
        if (txq.size() != exp_ack.size()) begin
            failures++;
            $display("FAIL %s_ack_count: got %0d want %0d", name, txq.size(), exp_ack.size());
        end else begin
            for (int i = 0; i < txq.size(); i++) begin
                checks++;
                if (txq[i] !== exp_ack[i]) begin
                    failures++;
                    $display("FAIL %s_ack[%0d]: got %02h want %02h", name, i, txq[i], exp_ack[i]);
                end
            end
        end
        txq.delete();
        exp_ack.delete();
    endtask

    task automatic check_pwm(string name);
        int base[3];
        repeat (PER + 4) tick();
        base = hi_cnt;
        repeat (PER) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (hi_cnt[i] - base[i] !== mduty[i] * (P + 1)) begin
                failures++;
                $display("FAIL %s_pwm[%0d]: got %0d high cycles want %0d", name, i,
                         hi_cnt[i] - base[i], mduty[i] * (P + 1));
            end
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({reg_dat_re, reg_dat_we} !== 2'b00) begin
            failures++; $display("FAIL reset_ctl: got re/we %b want 00", {reg_dat_re, reg_dat_we});
        end
        checks++;
        if (reg_dat_di !== 32'h0) begin
            failures++; $display("FAIL reset_di: got %h want 0", reg_dat_di);
        end
        checks++;
        if ({rgb_red, rgb_green, rgb_blue} !== 3'b000) begin
            failures++; $display("FAIL reset_rgb: got %b want 000", {rgb_red, rgb_green, rgb_blue});
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_r80();
        bit re_e[6] = '{1, 0, 1, 0, 1, 0};
        bit we_e[6] = '{0, 0, 0, 0, 1, 0};
        int r0 = re_cnt;
        send_str("R80");
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (reg_dat_re !== re_e[k]) begin
                failures++; $display("FAIL r80_re_t%0d: got %b want %b", k + 1, reg_dat_re, re_e[k]);
            end
            checks++;
            if (reg_dat_we !== we_e[k]) begin
                failures++; $display("FAIL r80_we_t%0d: got %b want %b", k + 1, reg_dat_we, we_e[k]);
            end
            if (k == 4) begin
                checks++;
                if (reg_dat_di !== 32'h4B) begin
                    failures++; $display("FAIL r80_di: got %h want 0000004b", reg_dat_di);
                end
            end
        end
        wait_idle("r80");
        checks++;
        if (re_cnt - r0 !== 3) begin
            failures++; $display("FAIL r80_pops: got %0d want 3", re_cnt - r0);
        end
        check_acks("r80");
        check_pwm("r80");
    endtask

    task automatic test_gff_crlf();
        int r0 = re_cnt;
        send_str("gFF\r\n");
        wait_idle("gff");
        checks++;
        if (re_cnt - r0 !== 5) begin
            failures++; $display("FAIL gff_pops: got %0d want 5", re_cnt - r0);
        end
        check_acks("gff");
        check_pwm("gff");
    endtask

    task automatic test_err_then_b10();
        send_str("Rx");
        send_str("B10");
        wait_idle("err");
        check_acks("err");
        check_pwm("err");
    endtask

    task automatic test_wait_stall();
        int n = 0, unstable = 0, r0;
        logic [31:0] d0;
        reg_dat_wait = 1'b1;
        send_str("G20B05");
        while (!we_s && n < 50) begin tick(); n++; end
        checks++;
        if (!we_s) begin failures++; $display("FAIL wait_we_rise: got 0 want 1"); end
        d0 = di_s;
        r0 = re_cnt;
        repeat (100) begin
            tick();
            if (!we_s || di_s !== d0) unstable++;
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL wait_stable: got %0d unstable cycles want 0", unstable); end
        checks++;
        if (d0 !== 32'h4B) begin failures++; $display("FAIL wait_di: got %h want 0000004b", d0); end
        checks++;
        if (re_cnt != r0 || rxq.size() != 3) begin
            failures++; $display("FAIL wait_no_pop: got pops=%0d queued=%0d want 0 and 3", re_cnt - r0, rxq.size());
        end
        reg_dat_wait = 1'b0;
        tick();
        checks++;
        if (we_s !== 1'b0) begin failures++; $display("FAIL wait_release: got we=%b want 0", we_s); end
        wait_idle("wait");
        check_acks("wait");
        check_pwm("wait");
    endtask

    task automatic test_off_midperiod();
        int base, n = 0;
        logic prev = 1'b1;
        send_str("R40G00B00");
        wait_idle("off_setup");
        check_acks("off_setup");
        repeat (PER + 4) tick();
        // red rises exactly at period start for any nonzero duty
        while (!(rgb_red && !prev) && n < 2 * PER) begin
            prev = rgb_red;
            tick();
            n++;
        end
        checks++;
        if (!(rgb_red && !prev)) begin failures++; $display("FAIL off_period_start: got no red rise want one"); end
        base = hi_cnt[0] - 1;
        repeat (20) tick();
        send_str("O");
        repeat (PER - 21) tick();
        checks++;
        if (hi_cnt[0] - base !== 64 * (P + 1)) begin
            failures++; $display("FAIL off_old_period: got %0d want %0d", hi_cnt[0] - base, 64 * (P + 1));
        end
        base = hi_cnt[0];
        repeat (PER) tick();
        checks++;
        if (hi_cnt[0] - base !== 0) begin
            failures++; $display("FAIL off_new_period: got %0d want 0", hi_cnt[0] - base);
        end
        wait_idle("off");
        check_acks("off");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        reg_dat_wait = 1'b1;
        send_str("R55");
        while (!we_s && n < 50) begin tick(); n++; end
        rst = 1'b1;
        tick();
        checks++;
        if ({reg_dat_re, reg_dat_we, rgb_red, rgb_green, rgb_blue} !== 5'b0 || reg_dat_di !== 32'h0) begin
            failures++;
            $display("FAIL rst_send: got re/we/rgb %b di %h want 00000 and 0",
                     {reg_dat_re, reg_dat_we, rgb_red, rgb_green, rgb_blue}, reg_dat_di);
        end
        rst = 1'b0;
        reg_dat_wait = 1'b0;
        tick();
        checks++;
        if (txq.size() != 0) begin failures++; $display("FAIL rst_send_ack: got %0d acks want 0", txq.size()); end
        txq.delete();
        model_reset();
        send_str("G1");
        n = 0;
        while (rxq.size() != 0 && n < 50) begin tick(); n++; end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        send_str("B01");
        wait_idle("rst_cmd");
        check_acks("rst_cmd");
        check_pwm("rst_cmd");
    endtask

    task automatic test_random();
        string chs  = "RGBrgb";
        string junk = "RGBrgbOo0123456789ABCDEFafxZ!\r\n ";
        for (int r = 0; r < 6; r++) begin
            for (int it = 0; it < 8; it++) begin
                int sel = $urandom_range(0, 9);
                byte unsigned c;
                if (sel < 7) begin
                    int d = $urandom_range(0, 255);
                    bit lc = 1'($urandom_range(0, 1));
                    c = chs[$urandom_range(0, 5)];
                    rxq.push_back(c); model_byte(c);
                    c = (d / 16 < 10) ? 8'(48 + d / 16) : 8'((lc ? 87 : 55) + d / 16);
                    rxq.push_back(c); model_byte(c);
                    c = (d % 16 < 10) ? 8'(48 + d % 16) : 8'((lc ? 87 : 55) + d % 16);
                    rxq.push_back(c); model_byte(c);
                end else if (sel == 7) begin
                    c = ($urandom_range(0, 1) != 0) ? 8'h4F : 8'h6F;
                    rxq.push_back(c); model_byte(c);
                end else begin
                    c = junk[$urandom_range(0, junk.len() - 1)];
                    rxq.push_back(c); model_byte(c);
                end
            end
            refresh_do();
            wait_idle("rand");
            check_acks("rand");
            check_pwm("rand");
        end
    endtask

    initial begin
        test_reset();
        test_r80();
        test_gff_crlf();
        test_err_then_b10();
        test_wait_stall();
        test_off_midperiod();
        test_reset_mid();
        test_random();
        checks++;
        if (mon_err != 0) begin
            failures++; $display("FAIL monitor: got %0d re/di violations want 0", mon_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
